// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake and FIFO write-port signals of the
// write-side arbiter. The master modport is the requester/FIFO side, the
// slave modport is the arbiter itself.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_full;
  logic                  wren;
  logic [WIDTH-1:0]      wdata;
  logic [IDW-1:0]        gnt_id;
  logic                  locked;
  logic                  burst_err;

  modport master (
    output req_valid, req_last, req_data, wr_full,
    input  req_ready, wren, wdata, gnt_id, locked, burst_err
  );

  modport slave (
    input  req_valid, req_last, req_data, wr_full,
    output req_ready, wren, wdata, gnt_id, locked, burst_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port
// among NREQ requesters in the wclk domain. Grant and transfer are
// combinational (zero-cycle grant); wr_full gates every beat.
// Burst locking is compiled in with `define FIFO_WR_ARB_LOCK_EN; without it
// every beat is arbitrated on its own and req_last is ignored.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic             wclk,
  input  logic             wrst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_idx;
  logic           rr_any;
  logic [IDW-1:0] cidx;
  logic [IDW-1:0] win_idx;
  logic           win_any;
  logic           port_open;
  logic           xfer;

`ifdef FIFO_WR_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  beat_cnt;
  logic           burst_err_q;
  logic           win_last;
`else
  logic           unused_last;
`endif

  // Round-robin search: first valid requester after rr_ptr, wrapping.
  always_comb begin
    rr_idx = rr_ptr;
    rr_any = 1'b0;
    cidx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cidx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!rr_any && bus.req_valid[cidx]) begin
        rr_idx = cidx;
        rr_any = 1'b1;
      end
    end
  end

`ifdef FIFO_WR_ARB_LOCK_EN
  // A locked burst pins the winner to its owner whether or not it is valid.
  assign win_idx = (state == LOCK) ? owner : rr_idx;
  assign win_any = (state == LOCK) | rr_any;
  assign win_last = bus.req_last[win_idx];
`else
  assign win_idx = rr_idx;
  assign win_any = rr_any;
  assign unused_last = ^bus.req_last;
`endif

  // No beat is accepted while reset is held, since no state could record it.
  assign port_open = win_any && !bus.wr_full && wrst_n;
  assign xfer      = port_open && bus.req_valid[win_idx];
  assign bus.wren  = xfer;
  assign bus.wdata = bus.req_data[int'(win_idx)*WIDTH +: WIDTH];

  // Ready is one-hot on the winner, or zero when stalled or idle.
  always_comb begin
    bus.req_ready = '0;
    if (port_open) bus.req_ready[win_idx] = 1'b1;
  end

`ifdef FIFO_WR_ARB_LOCK_EN
  // Arbitration FSM: pointer, burst ownership, beat counting, forced release.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state       <= IDLE;
      rr_ptr      <= IDW'(NREQ - 1);
      owner       <= '0;
      beat_cnt    <= '0;
      burst_err_q <= 1'b0;
    end else begin
      burst_err_q <= 1'b0;
      if (xfer) begin
        case (state)
          IDLE: begin
            rr_ptr <= win_idx;
            if (!win_last) begin
              state    <= LOCK;
              owner    <= win_idx;
              beat_cnt <= CW'(1);
            end
          end
          LOCK: begin
            beat_cnt <= beat_cnt + 1'b1;
            if (win_last) begin
              state  <= IDLE;
              rr_ptr <= owner;
            end else if (beat_cnt == CW'(MAX_BURST - 1)) begin
              // Burst too long: release so the owner's next beat re-arbitrates.
              state       <= IDLE;
              burst_err_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.locked    = (state == LOCK);
  assign bus.burst_err = burst_err_q;
  assign bus.gnt_id    = (state == LOCK) ? owner : rr_ptr;
`else
  // Pointer advances to each served requester.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rr_ptr <= IDW'(NREQ - 1);
    end else if (xfer) begin
      rr_ptr <= win_idx;
    end
  end

  assign bus.locked    = 1'b0;
  assign bus.burst_err = 1'b0;
  assign bus.gnt_id    = rr_ptr;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter sharing the single write port of the async FIFO write side among `NREQ` requesters in the `wclk` domain. Each requester uses a valid/ready handshake with a burst `last` marker. The arbiter drives `wren`/`wdata` into the FIFO write logic and gates every transfer with `wr_full`, so no beat is ever presented while the FIFO is full. Burst locking keeps a burst contiguous in the FIFO and is compiled in or out.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, ≥2.
- `WIDTH`, 8: data width per beat.
- `MAX_BURST`, 16: beat limit per locked burst, ≥2.

Ports (clock and reset first):
- `wclk` in 1: write-domain clock. One clock only.
- `wrst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: per-requester beat valid.
- `req_last` in NREQ: per-requester last beat of burst.
- `req_data` in NREQ*WIDTH: requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready` out NREQ: one-hot or zero; beat i transfers when `req_valid[i] && req_ready[i]`.
- `wr_full` in 1: FIFO full flag from the FIFO write side.
- `wren` out 1: FIFO write enable.
- `wdata` out WIDTH: FIFO write data.
- `gnt_id` out $clog2(NREQ): current or last winner index.
- `locked` out 1: high while a burst owns the port.
- `burst_err` out 1: one-cycle pulse on a forced release at `MAX_BURST`.

## Operation
- The transfer path is combinational. `wren = winner valid && !wr_full`. `wdata` = the winner's data. `req_ready[winner] = !wr_full`, and all other ready bits are 0.
- `wren` is never high while `wr_full` is high.
- Registered state: `rr_ptr` (last served index), `state`, `owner`, `beat_cnt` ($clog2(MAX_BURST)+1 bits).
- **IDLE state:**
  - Winner = first asserted `req_valid` searching from `rr_ptr+1` upward, modulo NREQ.
  - With no valid request there is no winner: `wren` = 0 and `req_ready` = 0.
  - On each transferred beat, `rr_ptr` ← winner.
  - If the beat has `last`=0, go to LOCK with `owner` ← winner and `beat_cnt` ← 1.
- **LOCK state:**
  - Winner = `owner` only. All other requesters see ready = 0.
  - Each transferred beat increments `beat_cnt`.
  - A transferred beat with `last`=1 returns the block to IDLE and sets `rr_ptr` ← `owner`.
  - If a beat transfers with `last`=0 and `beat_cnt == MAX_BURST-1`, the block is forced back to IDLE and `burst_err` pulses in the next cycle. The owner's following beats then re-arbitrate as a new burst.
  - If the owner drops `valid` mid-burst, the lock holds and the port idles.
- `wr_full` stalls the transfer only. Grant and state are unaffected.
- `gnt_id` = `owner` in LOCK, otherwise `rr_ptr`.
- `locked` = (state == LOCK).

## Timing
- Zero-cycle grant: a beat presented in IDLE transfers in the same cycle when `wr_full` = 0.
- State, pointer and counter update on `posedge wclk`.
- Reset while `wrst_n`=0:
  - state = IDLE, `rr_ptr` = NREQ-1 (so requester 0 has priority first), `owner` = 0, `beat_cnt` = 0.
  - `burst_err` = 0, `locked` = 0, `gnt_id` = NREQ-1.
  - Combinational outputs follow from this state.
- Reset asserted mid-burst aborts the lock immediately. No FIFO-side cleanup is performed.
- Simultaneous requests in IDLE: exactly one winner per cycle. Fairness: with all NREQ requesting single-beat bursts, each is served once every NREQ transfers.
- Single-beat burst (`last`=1 on the first beat): stays in IDLE and only updates `rr_ptr`.

## Configuration
- `FIFO_WR_ARB_LOCK_EN`:
  - Defined: LOCK state, `owner`, `beat_cnt` and `burst_err` behave as above.
  - Undefined: every beat is arbitrated independently in IDLE and `req_last` is ignored. `locked` and `burst_err` are tied to 0. `gnt_id` = `rr_ptr`.

## Test plan
- Reset, then `req_valid`=4'b1111 with all `last`=1 and `wr_full`=0 → `gnt_id` sequence 0,1,2,3,0, with one `wren` per cycle and `wdata` matching each source.
- Lock on, requester 2 sends a 3-beat burst while requester 0 is also valid → three consecutive `wren` from 2 with `req_ready[0]`=0, then requester 0 is served in the 4th cycle.
- `wr_full`=1 for 5 cycles during a burst → `wren`=0 and `req_ready`=0 throughout; the burst resumes on the same owner and no beat is lost or duplicated.
- Lock on, requester 1 streams 20 beats with `last`=0 and `MAX_BURST`=16 → forced release after the 16th beat, `burst_err` pulses one cycle, `locked` falls, and re-arbitration follows.
- `wrst_n` pulled low in the middle of a LOCK burst → `locked`=0, `wren`=0 and `gnt_id`=NREQ-1 immediately; after release, requester 0 wins first.
- Lock off, two requesters each with a 4-beat burst → beats interleave 0,1,0,1…; `locked` and `burst_err` stay 0.
